// File: rtl/div_issue_queue.sv
// -----------------------------------------------------------------------------
// div_issue_queue
//   Operand queue and issue stage in front of the 4-bit restoring divider.
//   Buffers {dividend, divisor} pairs from a valid/ready producer and presents
//   the head pair on did/dir. The divider loads did/dir on every edge where
//   div_st=1. A load of a real pair counts as an issue.
//
//   Optional feature macro: DIV_ZERO_FILTER_EN
//     When defined, a pair with a zero divisor is accepted on the handshake
//     but dropped, and err pulses for one cycle. When undefined, err is tied 0.
//
// Parameters
//   DEPTH     queue entries (power of two, 2..16)
//   CW        width of the issued-operation counter
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset (flushes the queue)
//   in_valid  producer presents a pair on in_did/in_dir
//   in_ready  queue can accept a pair (registered occupancy not full)
//   in_did    dividend in
//   in_dir    divisor in
//   div_st    divider idle/load flag, sampled only
//   did, dir  head pair to divider, 0/0 when empty
//   issued    one-cycle pulse after a pair was handed to the divider
//   issue_cnt pairs issued since reset, wraps modulo 2^CW
//   err       one-cycle pulse after a zero-divisor pair was dropped
//   empty     queue holds no pairs
//   full      queue holds DEPTH pairs
// -----------------------------------------------------------------------------
module div_issue_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_did,
   input  logic [3:0]    in_dir,
   input  logic          div_st,
   output logic [3:0]    did,
   output logic [3:0]    dir,
   output logic          issued,
   output logic [CW-1:0] issue_cnt,
   output logic          err,
   output logic          empty,
   output logic          full
);

   localparam int          PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   occ;
   logic          push_hs;
   logic          wr_en;
   logic          pop;
   logic          issued_p1;
   logic [CW-1:0] cnt_p1;

   // Status comes only from the registered occupancy, so in_ready never
   // depends on a pop happening in the same cycle.
   assign full     = (occ == FULL_OCC);
   assign empty    = (occ == '0);
   assign in_ready = !full;
   assign push_hs  = in_valid && in_ready;
   // A push into an empty queue is not visible as head until after the edge,
   // so an empty queue never pops.
   assign pop      = div_st && !empty;

`ifdef DIV_ZERO_FILTER_EN
   logic err_p1;

   assign wr_en = push_hs && (in_dir != 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_p1 <= 1'b0;
      end else begin
         err_p1 <= push_hs && (in_dir == 4'd0);
      end
   end

   assign err = err_p1;
`else
   assign wr_en = push_hs;
   assign err   = 1'b0;
`endif

   // Head pair; an empty queue feeds 0/0, which the divider treats as a
   // dummy pass.
   always_comb begin
      did = 4'd0;
      dir = 4'd0;
      if (!empty) begin
         {did, dir} = mem[rd_ptr];
      end
   end

   // ---- storage write stage ----
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {in_did, in_dir};
      end
   end

   // ---- pointer / occupancy / issue stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         issued_p1 <= 1'b0;
         cnt_p1    <= '0;
      end else begin
         issued_p1 <= pop;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            cnt_p1 <= cnt_p1 + CW'(1);
         end
         case ({wr_en, pop})
            2'b10:   occ <= occ + (PW+1)'(1);
            2'b01:   occ <= occ - (PW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   assign issued    = issued_p1;
   assign issue_cnt = cnt_p1;

endmodule

// File: tb/tb_div_issue_queue.sv
module tb_div_issue_queue;
   localparam int DEPTH = 4;
   localparam int CW    = 8;
`ifdef DIV_ZERO_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_did;
   logic [3:0]    in_dir;
   logic          div_st;
   logic [3:0]    did;
   logic [3:0]    dir;
   logic          issued;
   logic [CW-1:0] issue_cnt;
   logic          err;
   logic          empty;
   logic          full;

   int errors = 0;
   int checks = 0;

   // Reference model: an ordered list of pending pairs plus event flags.
   logic [7:0]    mq[$];
   logic [CW-1:0] m_cnt;
   logic          m_issued;
   logic          m_err;

   always #5 clk = ~clk;

   div_issue_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_did(in_did), .in_dir(in_dir), .div_st(div_st), .did(did), .dir(dir),
      .issued(issued), .issue_cnt(issue_cnt), .err(err), .empty(empty), .full(full)
   );

   // Apply one cycle of stimulus, advance the model by the same edge, and
   // return 1 ns after that edge.
   task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic st);
      logic do_pop;
      logic do_push;
      logic [7:0] dropped;
      in_valid = v; in_did = a; in_dir = b; div_st = st;
      do_pop  = st && (mq.size() != 0);
      do_push = v && (mq.size() < DEPTH);
      m_issued = do_pop;
      m_err    = 1'b0;
      if (do_pop) begin
         dropped = mq.pop_front();
         m_cnt   = m_cnt + 1'b1;
      end
      if (do_push) begin
         if (FILT && b == 4'd0) m_err = 1'b1;
         else                   mq.push_back({a, b});
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b1; in_did = 4'd6; in_dir = 4'd1; div_st = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; div_st = 1'b0;
      mq.delete();
      m_cnt = '0; m_issued = 1'b0; m_err = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      checks++; if ({did, dir} !== 8'h00) begin errors++; $display("FAIL reset_head got=%h exp=00", {did, dir}); end
      checks++; if ({issued, err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {issued, err}); end
      checks++; if (issue_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", issue_cnt); end
   endtask

   task automatic test_basic_issue();
      do_reset();
      step(1'b1, 4'd13, 4'd3, 1'b0);
      in_valid = 1'b0;
      checks++; if ({did, dir} !== {4'd13, 4'd3}) begin errors++; $display("FAIL basic_head got=%0d/%0d exp=13/3", did, dir); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_notempty got=%b exp=0", empty); end
      step(1'b0, 4'd0, 4'd0, 1'b1);
      checks++; if (issued !== 1'b1) begin errors++; $display("FAIL basic_issued got=%b exp=1", issued); end
      checks++; if (issue_cnt !== CW'(1)) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", issue_cnt); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b exp=1", empty); end
      step(1'b0, 4'd0, 4'd0, 1'b0);
      checks++; if (issued !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", issued); end
   endtask

   // Fill past DEPTH, then pop and push on the same full edge.
   task automatic test_fill_and_full();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== (i < DEPTH)) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, in_ready, (i < DEPTH)); end
         step(1'b1, 4'(i + 1), 4'(i + 2), 1'b0);
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
      // Pair 5 is still offered; pop happens, push must not.
      step(1'b1, 4'd5, 4'd6, 1'b1);
      checks++; if ({full, in_ready, issued} !== 3'b011) begin errors++; $display("FAIL fullpop_status got=%b exp=011", {full, in_ready, issued}); end
      checks++; if ({did, dir} !== {4'd2, 4'd3}) begin errors++; $display("FAIL fullpop_head got=%0d/%0d exp=2/3", did, dir); end
      step(1'b1, 4'd5, 4'd6, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fifth_accept got=%b exp=1", full); end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if ({did, dir} !== {4'(i + 1), 4'(i + 2)}) begin errors++; $display("FAIL order[%0d] got=%0d/%0d exp=%0d/%0d", i, did, dir, i + 1, i + 2); end
         step(1'b0, 4'd0, 4'd0, 1'b1);
      end
      checks++; if ({empty, issue_cnt} !== {1'b1, CW'(5)}) begin errors++; $display("FAIL drain got=%b/%0d exp=1/5", empty, issue_cnt); end
   endtask

   task automatic test_empty_push_pop();
      do_reset();
      step(1'b1, 4'd7, 4'd2, 1'b1);
      checks++; if ({issued, empty} !== 2'b00) begin errors++; $display("FAIL emptypp_noissue got=%b exp=00", {issued, empty}); end
      checks++; if ({did, dir, issue_cnt} !== {4'd7, 4'd2, CW'(0)}) begin errors++; $display("FAIL emptypp_head got=%h exp=%h", {did, dir, issue_cnt}, {4'd7, 4'd2, CW'(0)}); end
      step(1'b0, 4'd0, 4'd0, 1'b1);
      checks++; if ({issued, empty, issue_cnt} !== {2'b11, CW'(1)}) begin errors++; $display("FAIL emptypp_issue got=%h exp=%h", {issued, empty, issue_cnt}, {2'b11, CW'(1)}); end
   endtask

   task automatic test_zero_divisor();
      do_reset();
      step(1'b1, 4'd9, 4'd0, 1'b0);
      checks++; if (err !== FILT) begin errors++; $display("FAIL zero_err got=%b exp=%b", err, FILT); end
      checks++; if (empty !== FILT) begin errors++; $display("FAIL zero_empty got=%b exp=%b", empty, FILT); end
      step(1'b1, 4'd9, 4'd2, 1'b0);
      in_valid = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err_width got=%b exp=0", err); end
      checks++; if ({did, dir} !== {4'd9, (FILT ? 4'd2 : 4'd0)}) begin errors++; $display("FAIL zero_head got=%0d/%0d exp=9/%0d", did, dir, FILT ? 2 : 0); end
      step(1'b0, 4'd0, 4'd0, 1'b1);
      checks++; if ({issued, empty} !== {1'b1, FILT}) begin errors++; $display("FAIL zero_after got=%b exp=%b", {issued, empty}, {1'b1, FILT}); end
   endtask

   task automatic test_flush();
      do_reset();
      step(1'b1, 4'd11, 4'd3, 1'b0);
      step(1'b1, 4'd12, 4'd4, 1'b0);
      step(1'b1, 4'd13, 4'd5, 1'b1);
      do_reset();
      checks++; if ({empty, did, dir, issue_cnt} !== {1'b1, 8'h00, CW'(0)}) begin errors++; $display("FAIL flush_state got=%h exp=%h", {empty, did, dir, issue_cnt}, {1'b1, 8'h00, CW'(0)}); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'd0, 4'd0, 1'b1);
         checks++; if ({issued, issue_cnt} !== {1'b0, CW'(0)}) begin errors++; $display("FAIL flush_noissue[%0d] got=%h exp=%h", i, {issued, issue_cnt}, {1'b0, CW'(0)}); end
      end
   endtask

   // Random traffic; long enough to wrap issue_cnt.
   task automatic test_random();
      logic [7:0] exp_head;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         exp_head = (mq.size() != 0) ? mq[0] : 8'h00;
         checks++; if ({empty, full, in_ready} !== {mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH}) begin
            errors++; $display("FAIL rnd_status[%0d] got=%b exp=%b", c, {empty, full, in_ready}, {mq.size() == 0, mq.size() == DEPTH, mq.size() != DEPTH}); end
         checks++; if ({did, dir} !== exp_head) begin errors++; $display("FAIL rnd_head[%0d] got=%h exp=%h", c, {did, dir}, exp_head); end
         checks++; if ({issued, err} !== {m_issued, m_err}) begin errors++; $display("FAIL rnd_pulse[%0d] got=%b exp=%b", c, {issued, err}, {m_issued, m_err}); end
         checks++; if (issue_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", c, issue_cnt, m_cnt); end
         step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_did = 4'd0; in_dir = 4'd0; div_st = 1'b0;
      test_reset();
      test_basic_issue();
      test_fill_and_full();
      test_empty_push_pop();
      test_zero_divisor();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/div_issue_queue.md
# div_issue_queue

Operand queue and issue stage placed directly upstream of the 4-bit restoring divider. It buffers dividend/divisor pairs arriving on a valid/ready handshake. It presents the head pair on the divider's `did`/`dir` inputs so that the divider captures it on its next load edge, when `st`=1. It also counts issued operations and, optionally, filters divide-by-zero requests.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `CW`, 8: width of the issued-operation counter.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a pair on `in_did`/`in_dir`.
- `in_ready`  out  1  queue accepts a pair this cycle.
- `in_did`  in  4  dividend.
- `in_dir`  in  4  divisor.
- `div_st`  in  1  divider idle/load flag; divider loads `did`/`dir` on every edge where this is 1.
- `did`  out  4  dividend to divider.
- `dir`  out  4  divisor to divider.
- `issued`  out  1  one-cycle pulse; a pair was handed to the divider on the previous edge.
- `issue_cnt`  out  CW  total pairs issued since reset; wraps modulo 2^CW.
- `err`  out  1  one-cycle pulse; a zero divisor was dropped (only with the macro defined, else tied 0).
- `empty`, `full`  out  1  queue status.

## Operation
- Storage: circular buffer `DEPTH`x8 bits, holding `{did,dir}`.
  - Read pointer and write pointer, each log2(DEPTH) bits, wrap naturally.
  - Occupancy counter, log2(DEPTH)+1 bits.
- `in_ready` = !`full`, derived from the registered occupancy counter. It is not a function of this cycle's pop.
- Push: `in_valid` && `in_ready` at an edge.
  - Entry written at the write pointer.
  - Write pointer +1.
- Pop (issue): `div_st` && !`empty` at an edge.
  - Read pointer +1.
  - `issue_cnt` +1.
  - `issued` set to 1 for the next cycle.
- Simultaneous push and pop, not full and not empty: both happen; occupancy unchanged.
- Full: `in_ready`=0, so no push occurs even if a pop happens on the same edge.
- Empty with push on the same edge: no pop. The new entry becomes head after the edge; there is no bypass path.
- `did`/`dir` are combinational from the head entry when !`empty`, else 0/0.
  - When empty, the divider therefore loads 0/0 and runs a dummy 16-cycle pass.
  - The next issue happens on its following `st` edge; this is accepted behaviour.
- `div_st` is sampled only; the block never stalls or resets the divider.

## Timing
- Reset values, on the edge with `rst`=1:
  - Pointers 0, occupancy 0.
  - `empty`=1, `full`=0, `in_ready`=1.
  - `did`=`dir`=0, `issued`=0, `issue_cnt`=0, `err`=0.
  - Reset takes priority over push and pop on the same edge.
- Reset mid-operation: the queue is flushed and queued pairs are lost. A pair already captured by the divider completes there, unaffected.
- Minimum latency, push to issue: 1 edge. A pair pushed at edge N is on `did`/`dir` after edge N and is issued at the first edge >N with `div_st`=1.
- Throughput: one issue per divider load edge.
- `issued` and `err` are registered pulses, exactly 1 cycle wide per event.
- `issue_cnt` wraps from 2^CW-1 to 0 with no flag.

## Configuration
- `DIV_ZERO_FILTER_EN` defined:
  - A handshake with `in_dir`==0 completes normally (`in_ready` honoured).
  - The pair is not written.
  - `err` pulses on the next cycle.
  - Pointers and occupancy are unchanged.
- Not defined:
  - Zero divisors are queued and issued like any pair; the divider returns its own result.
  - `err` is constant 0.

## Test plan
- Reset, then push (13,3) with `div_st`=0; raise `div_st` for one edge.
  - `did`=13, `dir`=3 at that edge.
  - `issued`=1 next cycle, `issue_cnt`=1, `empty`=1.
  - Divider reports q=4, r=1 when its `st` returns to 1.
- Push 5 pairs with `DEPTH`=4 and `div_st`=0.
  - `in_ready` drops after the 4th push and the 5th is held.
  - Pop once; the 5th is accepted the cycle after.
  - Issue order matches push order.
- Full queue with push and pop on the same edge: the push is not taken and occupancy goes 4→3.
- Empty queue, push and `div_st`=1 on the same edge.
  - No issue and `issued`=0.
  - The entry issues at the next `div_st` edge.
- With `DIV_ZERO_FILTER_EN`: push (9,0) then (9,2).
  - `err` pulses once; only (9,2) is queued.
  - Without the macro, both are queued.
- Queue three pairs, assert `rst` for one edge: `empty`=1, `issue_cnt`=0, `did`/`dir`=0; no later issue of the flushed pairs.
